// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU slice: the default datapath width and the
// operation codes decoded by the top level.
//
// Optional feature macro: ALU_FLAGS_EN (carry/zero flag outputs on alu).

package alu_pkg;

  // Default operand/result width in bits.
  localparam int ALU_WIDTH = 4;

  // Operation select encoding; all eight codes are defined.
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } alu_op_e;

endpackage

// File: rtl/alu_addsub.sv
// alu_addsub
// Combinational adder/subtractor shared by the ADD and SUB operations.
//
// Ports:
//   a_i     operand A, unsigned
//   b_i     operand B, unsigned
//   sub_i   0 = a_i + b_i, 1 = a_i - b_i
//   sum_o   result modulo 2**WIDTH
//   carry_o carry out on add, borrow (a_i < b_i) on subtract
//
// Optional feature macro: none (carry_o is always produced; alu decides
// whether to register it depending on ALU_FLAGS_EN).

module alu_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  // One extra bit of headroom: on add the top bit is the carry, on subtract
  // a zero-extended difference goes negative exactly when a < b, so the top
  // bit is then the borrow.
  logic [WIDTH:0] wideResult;

  always_comb begin
    if (sub_i) begin
      wideResult = {1'b0, a_i} - {1'b0, b_i};
    end else begin
      wideResult = {1'b0, a_i} + {1'b0, b_i};
    end
  end

  assign sum_o   = wideResult[WIDTH-1:0];
  assign carry_o = wideResult[WIDTH];

endmodule

// File: rtl/alu.sv
// alu
// Single-cycle-latency ALU. The result of (a op b) is computed
// combinationally and registered on every rising clk edge; there is no
// enable, so a new operation is accepted each cycle.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous, active-high reset; clears all outputs
//   a, b    unsigned operands
//   op      operation select (see alu_pkg::alu_op_e)
//   alu_out registered result
//   carry   registered carry/borrow/shift-out flag (ALU_FLAGS_EN only)
//   zero    registered "result is zero" flag       (ALU_FLAGS_EN only)
//
// Optional feature macro: ALU_FLAGS_EN adds the carry and zero ports and
// their registers. alu_out behaves identically in both builds.

module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
`ifdef ALU_FLAGS_EN
  output logic             carry,
  output logic             zero,
`endif
  output logic [WIDTH-1:0] alu_out
);

  logic [WIDTH-1:0] result_d;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] addSubSum;
  logic             isSub;

`ifdef ALU_FLAGS_EN
  logic addSubCarry;
  logic carry_d;
  logic carry_q;
  logic zero_q;
`else
  // Borrow/carry from the adder has no consumer when flags are compiled out.
  logic addSubCarry_unused;
`endif

  assign isSub = (op == OP_SUB);

  alu_addsub #(
    .WIDTH(WIDTH)
  ) u_addsub (
    .a_i    (a),
    .b_i    (b),
    .sub_i  (isSub),
    .sum_o  (addSubSum),
`ifdef ALU_FLAGS_EN
    .carry_o(addSubCarry)
`else
    .carry_o(addSubCarry_unused)
`endif
  );

  // Result selection. Every op code maps to a defined result, so no input
  // combination can leave result_d unknown.
  always_comb begin
    result_d = '0;
    unique case (alu_op_e'(op))
      OP_ADD,
      OP_SUB:  result_d = addSubSum;
      OP_AND:  result_d = a & b;
      OP_OR:   result_d = a | b;
      OP_XOR:  result_d = a ^ b;
      OP_NOT:  result_d = ~a;
      OP_SHL:  result_d = {a[WIDTH-2:0], 1'b0};
      OP_SHR:  result_d = {1'b0, a[WIDTH-1:1]};
      default: result_d = '0;
    endcase
  end

`ifdef ALU_FLAGS_EN
  // Carry source: adder carry/borrow for arithmetic, the bit shifted out for
  // shifts, and 0 for the bitwise logic ops.
  always_comb begin
    carry_d = 1'b0;
    unique case (alu_op_e'(op))
      OP_ADD,
      OP_SUB:  carry_d = addSubCarry;
      OP_SHL:  carry_d = a[WIDTH-1];
      OP_SHR:  carry_d = a[0];
      default: carry_d = 1'b0;
    endcase
  end

  // Flag registers. Zero is derived from the same wrapped result that is
  // captured into alu_out, so it tracks the registered value exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      carry_q <= carry_d;
      zero_q  <= (result_d == '0);
    end
  end

  assign carry = carry_q;
  assign zero  = zero_q;
`endif

  // Result register; reset wins over whatever operation is presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign alu_out = result_q;

endmodule

// File: tb/tb_alu.sv
// tb_alu
// Self-checking bench for alu (WIDTH=4). Inputs are driven 1 time unit
// after a rising edge and outputs are sampled 1 time unit after the next
// rising edge. Flag checks are compiled in when ALU_FLAGS_EN is defined.

module tb_alu;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic [2:0] op;
  logic [3:0] alu_out;
`ifdef ALU_FLAGS_EN
  logic       carry;
  logic       zero;
`endif

  int compared;
  int mismatched;

  alu #(
    .WIDTH(4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .op     (op),
`ifdef ALU_FLAGS_EN
    .carry  (carry),
    .zero   (zero),
`endif
    .alu_out(alu_out)
  );

  // 10 time-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour, returned as {carry, result}.
  function automatic logic [4:0] refModel(input logic [3:0] ra, input logic [3:0] rb,
                                          input logic [2:0] rop);
    int s;
    logic [3:0] r;
    logic       c;
    r = 4'h0;
    c = 1'b0;
    case (rop)
      3'b000: begin s = int'(ra) + int'(rb); r = 4'(s % 16); c = (s >= 16); end
      3'b001: begin s = int'(ra) - int'(rb) + 16; r = 4'(s % 16); c = (ra < rb); end
      3'b010: r = ra & rb;
      3'b011: r = ra | rb;
      3'b100: r = ra ^ rb;
      3'b101: r = ~ra;
      3'b110: begin r = 4'((int'(ra) * 2) % 16); c = ra[3]; end
      default: begin r = 4'(int'(ra) / 2); c = ra[0]; end
    endcase
    return {c, r};
  endfunction

  // Present one set of inputs and advance to just after the capturing edge.
  task automatic applyStimulus(input logic r, input logic [3:0] ta, input logic [3:0] tb,
                               input logic [2:0] top);
    rst = r;
    a   = ta;
    b   = tb;
    op  = top;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    applyStimulus(1'b1, 4'h5, 4'h3, 3'b101);
    compared++;
    if (alu_out !== 4'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_out: got %h expected %h", alu_out, 4'h0);
    end
`ifdef ALU_FLAGS_EN
    compared++;
    if (carry !== 1'b0 || zero !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_flags: got c=%b z=%b expected c=0 z=0", carry, zero);
    end
`endif
  endtask

  task automatic test_op_sweep();
    logic [3:0] expOut [8];
    logic       expCarry [8];
    expOut   = '{4'h4, 4'h2, 4'h1, 4'h3, 4'h2, 4'hC, 4'h6, 4'h1};
    expCarry = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 4'h3, 4'h1, 3'(i));
      compared++;
      if (alu_out !== expOut[i]) begin
        mismatched++;
        $display("[TB] FAIL sweep_op%0d_out: got %h expected %h", i, alu_out, expOut[i]);
      end
`ifdef ALU_FLAGS_EN
      compared++;
      if (carry !== expCarry[i] || zero !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL sweep_op%0d_flags: got c=%b z=%b expected c=%b z=0",
                 i, carry, zero, expCarry[i]);
      end
`else
      if (expCarry[i] === 1'bx) $display("[TB] unreachable");
`endif
    end
  endtask

  task automatic test_boundaries();
    // Inputs, expected result, carry, zero for the wrap/shift-out corners.
    logic [3:0] va [5];
    logic [3:0] vb [5];
    logic [2:0] vop [5];
    logic [3:0] vOut [5];
    logic       vC [5];
    logic       vZ [5];
    va   = '{4'hF, 4'h1, 4'h8, 4'h1, 4'h0};
    vb   = '{4'h1, 4'h3, 4'h0, 4'h0, 4'h0};
    vop  = '{3'b000, 3'b001, 3'b110, 3'b111, 3'b001};
    vOut = '{4'h0, 4'hE, 4'h0, 4'h0, 4'h0};
    vC   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vZ   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, va[i], vb[i], vop[i]);
      compared++;
      if (alu_out !== vOut[i]) begin
        mismatched++;
        $display("[TB] FAIL boundary%0d_out: got %h expected %h", i, alu_out, vOut[i]);
      end
`ifdef ALU_FLAGS_EN
      compared++;
      if (carry !== vC[i] || zero !== vZ[i]) begin
        mismatched++;
        $display("[TB] FAIL boundary%0d_flags: got c=%b z=%b expected c=%b z=%b",
                 i, carry, zero, vC[i], vZ[i]);
      end
`else
      if (vC[i] === 1'bx || vZ[i] === 1'bx) $display("[TB] unreachable");
`endif
    end
  endtask

  task automatic test_reset_release();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 4'hF, 4'hF, 3'b000);
      compared++;
      if (alu_out !== 4'h0) begin
        mismatched++;
        $display("[TB] FAIL hold_reset%0d_out: got %h expected %h", i, alu_out, 4'h0);
      end
`ifdef ALU_FLAGS_EN
      compared++;
      if (carry !== 1'b0 || zero !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL hold_reset%0d_flags: got c=%b z=%b expected c=0 z=0", i, carry, zero);
      end
`endif
    end
    applyStimulus(1'b0, 4'hF, 4'hF, 3'b000);
    compared++;
    if (alu_out !== 4'hE) begin
      mismatched++;
      $display("[TB] FAIL release_out: got %h expected %h", alu_out, 4'hE);
    end
`ifdef ALU_FLAGS_EN
    compared++;
    if (carry !== 1'b1 || zero !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL release_flags: got c=%b z=%b expected c=1 z=0", carry, zero);
    end
`endif
  endtask

  task automatic test_mid_reset();
    applyStimulus(1'b0, 4'h6, 4'h5, 3'b011);
    compared++;
    if (alu_out !== 4'h7) begin
      mismatched++;
      $display("[TB] FAIL pre_mid_reset_out: got %h expected %h", alu_out, 4'h7);
    end
    // The operation presented together with reset must be discarded.
    applyStimulus(1'b1, 4'h9, 4'h2, 3'b000);
    compared++;
    if (alu_out !== 4'h0) begin
      mismatched++;
      $display("[TB] FAIL mid_reset_out: got %h expected %h", alu_out, 4'h0);
    end
    applyStimulus(1'b0, 4'h9, 4'h2, 3'b100);
    compared++;
    if (alu_out !== 4'hB) begin
      mismatched++;
      $display("[TB] FAIL post_mid_reset_out: got %h expected %h", alu_out, 4'hB);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ra;
    logic [3:0] rb;
    logic [2:0] rop;
    logic [4:0] expected;
    for (int i = 0; i < 1000; i++) begin
      ra  = 4'($urandom_range(0, 15));
      rb  = 4'($urandom_range(0, 15));
      rop = 3'($urandom_range(0, 7));
      expected = refModel(ra, rb, rop);
      applyStimulus(1'b0, ra, rb, rop);
      compared++;
      if (alu_out !== expected[3:0]) begin
        mismatched++;
        $display("[TB] FAIL random%0d_out a=%h b=%h op=%0d: got %h expected %h",
                 i, ra, rb, rop, alu_out, expected[3:0]);
      end
`ifdef ALU_FLAGS_EN
      compared++;
      if (carry !== expected[4] || zero !== (expected[3:0] == 4'h0)) begin
        mismatched++;
        $display("[TB] FAIL random%0d_flags a=%h b=%h op=%0d: got c=%b z=%b expected c=%b z=%b",
                 i, ra, rb, rop, carry, zero, expected[4], (expected[3:0] == 4'h0));
      end
`endif
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst = 1'b1;
    a   = 4'h0;
    b   = 4'h0;
    op  = 3'b000;
    #1;
    test_reset();
    test_op_sweep();
    test_boundaries();
    test_reset_release();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
